// File: rtl/dds_freq_sched_if.sv
// dds_freq_sched_if: FTW update request bus between the requesters
// (b_to_f result path, host register interface, ...) and dds_freq_sched.
// Channel k owns req_valid[k], req_ready[k] and req_ftw[k*FTW_W +: FTW_W].
interface dds_freq_sched_if #(
  parameter int N_CH  = 4,
  parameter int FTW_W = 32
);
  logic [N_CH-1:0]       req_valid;
  logic [N_CH*FTW_W-1:0] req_ftw;
  logic [N_CH-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_ftw,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_ftw,
    output req_ready
  );
endinterface

// File: rtl/dds_freq_sched.sv
// dds_freq_sched: round-robin scheduler that moves FTW update requests into
// per-channel shadow registers and commits them to the dds_slave freq inputs,
// either right after each grant or all together on a dds_sync pulse.
// Optional feature macro: DDS_SCHED_LOST_CNT_EN builds the saturating
// counter of pending words overwritten before they were committed; without
// it o_lost_cnt is tied to zero.
module dds_freq_sched #(
  parameter int N_CH  = 4,
  parameter int FTW_W = 32
) (
  input  logic                  int_dds_clk_in,
  input  logic                  reset,
  dds_freq_sched_if.slave       i_req,
  input  logic [N_CH-1:0]       i_ch_en,
  input  logic                  i_mode_sync,
  input  logic                  i_sync_in,
  output logic [N_CH*FTW_W-1:0] o_dds_freq,
  output logic [N_CH-1:0]       o_update_strobe,
  output logic [N_CH-1:0]       o_dds_dis,
  output logic [N_CH-1:0]       o_pending,
  output logic                  o_busy,
  output logic [7:0]            o_lost_cnt
);

  localparam int PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW1 = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      r_grant_idx;
  logic [PW-1:0]      w_sel_idx;
  logic [PW-1:0]      w_ptr_nxt;
  logic [N_CH-1:0]    w_elig;
  logic [N_CH-1:0]    w_sel_onehot;
  logic               w_any_elig;
  logic               w_any_pending;
  logic               w_transfer;
  logic               r_sync_flag;
  logic [N_CH-1:0]    r_pending;
  logic [N_CH-1:0]    r_req_ready;
  logic [N_CH-1:0]    r_update_strobe;
  logic [N_CH-1:0]    r_dds_dis;
  logic               r_busy;
  logic [FTW_W-1:0]   r_shadow   [N_CH];
  logic [FTW_W-1:0]   r_dds_freq [N_CH];
  logic [FTW_W-1:0]   w_req_ftw  [N_CH];

  // Unpack the flat request words and pack the committed words.
  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign w_req_ftw[g]                   = i_req.req_ftw[g*FTW_W +: FTW_W];
    assign o_dds_freq[g*FTW_W +: FTW_W]   = r_dds_freq[g];
  end

  assign w_elig        = i_req.req_valid & i_ch_en;
  assign w_any_elig    = |w_elig;
  assign w_any_pending = |r_pending;
  assign w_sel_onehot  = N_CH'(1'b1) << w_sel_idx;
  assign w_transfer    = (r_state == S_GRANT) && i_req.req_valid[r_grant_idx];
  assign w_ptr_nxt     = (r_grant_idx == PW'(N_CH - 1)) ? {PW{1'b0}}
                                                        : r_grant_idx + PW'(1);

  assign i_req.req_ready = r_req_ready;
  assign o_update_strobe = r_update_strobe;
  assign o_dds_dis       = r_dds_dis;
  assign o_pending       = r_pending;
  assign o_busy          = r_busy;

  // Round-robin pick: first eligible channel at or after the pointer, wrapping.
  always_comb begin : arb_c
    logic [PW1-1:0] v_sum;
    logic [PW-1:0]  v_idx;
    logic           v_found;
    v_sum     = {PW1{1'b0}};
    v_idx     = {PW{1'b0}};
    v_found   = 1'b0;
    w_sel_idx = {PW{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      v_sum = {1'b0, r_rr_ptr} + PW1'(i);
      if (v_sum >= PW1'(N_CH)) begin
        v_sum = v_sum - PW1'(N_CH);
      end else begin
        v_sum = v_sum;
      end
      v_idx = v_sum[PW-1:0];
      if (!v_found && w_elig[v_idx]) begin
        v_found   = 1'b1;
        w_sel_idx = v_idx;
      end else begin
        v_found = v_found;
      end
    end
  end

  // Next-state logic: commits take priority over new grants in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if ((r_sync_flag || i_sync_in) && w_any_pending) begin
          w_state_nxt = S_COMMIT;
        end else if (!i_mode_sync && w_any_pending) begin
          w_state_nxt = S_COMMIT;
        end else if (w_any_elig) begin
          w_state_nxt = S_GRANT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!i_mode_sync && w_transfer) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Grant bookkeeping: latch the winner and pulse its ready during GRANT.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      r_grant_idx <= {PW{1'b0}};
      r_req_ready <= {N_CH{1'b0}};
      r_rr_ptr    <= {PW{1'b0}};
    end else begin
      if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT)) begin
        r_grant_idx <= w_sel_idx;
        r_req_ready <= w_sel_onehot;
      end else begin
        r_req_ready <= {N_CH{1'b0}};
      end
      if (w_transfer) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Shadow capture on a GRANT transfer; commit of every pending word in COMMIT.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        r_shadow[k]   <= {FTW_W{1'b0}};
        r_dds_freq[k] <= {FTW_W{1'b0}};
      end
      r_pending       <= {N_CH{1'b0}};
      r_update_strobe <= {N_CH{1'b0}};
    end else begin
      r_update_strobe <= {N_CH{1'b0}};
      case (r_state)
        S_GRANT: begin
          if (w_transfer) begin
            r_shadow[r_grant_idx]  <= w_req_ftw[r_grant_idx];
            r_pending[r_grant_idx] <= 1'b1;
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < N_CH; k++) begin
            if (r_pending[k]) begin
              r_dds_freq[k] <= r_shadow[k];
            end
          end
          r_update_strobe <= r_pending;
          r_pending       <= {N_CH{1'b0}};
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky sync: consumed on COMMIT entry, discarded when nothing is pending.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      r_sync_flag <= 1'b0;
    end else if (w_state_nxt == S_COMMIT) begin
      r_sync_flag <= 1'b0;
    end else if ((r_state == S_IDLE) && !w_any_pending) begin
      r_sync_flag <= 1'b0;
    end else if (i_sync_in) begin
      r_sync_flag <= 1'b1;
    end
  end

  // Channel disable follows ch_en with one cycle of lag.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      r_dds_dis <= {N_CH{1'b0}};
    end else begin
      r_dds_dis <= ~i_ch_en;
    end
  end

`ifdef DDS_SCHED_LOST_CNT_EN
  logic [7:0] r_lost_cnt;

  // Count overwrites of words that were still waiting to be committed.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      r_lost_cnt <= 8'd0;
    end else if (w_transfer && r_pending[r_grant_idx] && (r_lost_cnt != 8'hFF)) begin
      r_lost_cnt <= r_lost_cnt + 8'd1;
    end
  end

  assign o_lost_cnt = r_lost_cnt;
`else
  assign o_lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dds_freq_sched.sv
// tb_dds_freq_sched: directed test of dds_freq_sched with hand-computed
// expectations for immediate mode, round-robin order, sync mode, channel
// disable and reset during COMMIT.
module tb_dds_freq_sched;

  localparam int N_CH  = 4;
  localparam int FTW_W = 32;
`ifdef DDS_SCHED_LOST_CNT_EN
  localparam logic [7:0] LOST_EXP = 8'd1;
`else
  localparam logic [7:0] LOST_EXP = 8'd0;
`endif

  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       ch_en;
  logic                  mode_sync;
  logic                  sync_in;
  logic [N_CH*FTW_W-1:0] dds_freq;
  logic [N_CH-1:0]       update_strobe;
  logic [N_CH-1:0]       dds_dis;
  logic [N_CH-1:0]       pending;
  logic                  busy;
  logic [7:0]            lost_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dds_freq_sched_if #(.N_CH(N_CH), .FTW_W(FTW_W)) req_bus ();

  dds_freq_sched #(.N_CH(N_CH), .FTW_W(FTW_W)) dut (
    .int_dds_clk_in  (clk),
    .reset           (reset),
    .i_req           (req_bus),
    .i_ch_en         (ch_en),
    .i_mode_sync     (mode_sync),
    .i_sync_in       (sync_in),
    .o_dds_freq      (dds_freq),
    .o_update_strobe (update_strobe),
    .o_dds_dis       (dds_dis),
    .o_pending       (pending),
    .o_busy          (busy),
    .o_lost_cnt      (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fq(input int k);
    return dds_freq[k*FTW_W +: FTW_W];
  endfunction

  // One clock; a requester drops valid once its ready was seen at the edge.
  task automatic step();
    logic [N_CH-1:0] rdy;
    rdy = req_bus.req_ready;
    @(posedge clk);
    #1;
    req_bus.req_valid = req_bus.req_valid & ~rdy;
  endtask

  task automatic set_req(input int k, input logic [31:0] v);
    req_bus.req_ftw[k*FTW_W +: FTW_W] = v;
    req_bus.req_valid[k] = 1'b1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req_bus.req_valid = '0;
    sync_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [1:0]  ord [5];
  logic [31:0] val [5];

  initial begin
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0;
    val[0] = 32'h1000_0001; val[1] = 32'h2000_0002; val[2] = 32'h3000_0003;
    val[3] = 32'h4000_0004; val[4] = 32'h5555_AAAA;

    reset = 1'b1;
    ch_en = 4'hF;
    mode_sync = 1'b0;
    sync_in = 1'b0;
    req_bus.req_valid = '0;
    req_bus.req_ftw = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_freq_lo", 64'(dds_freq[63:0]), 64'd0);
    check("rst_freq_hi", 64'(dds_freq[127:64]), 64'd0);
    check("rst_strobe", 64'(update_strobe), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_bus.req_ready), 64'd0);
    check("rst_lost", 64'(lost_cnt), 64'd0);

    // Immediate mode, single request on ch1
    set_req(1, 32'h1234_5678);
    step();
    check("imm_ready_c1", 64'(req_bus.req_ready), 64'h2);
    check("imm_busy_c1", 64'(busy), 64'd1);
    step();
    check("imm_ready_c2", 64'(req_bus.req_ready), 64'h0);
    check("imm_strobe_c2", 64'(update_strobe), 64'h0);
    step();
    check("imm_freq1", 64'(fq(1)), 64'h1234_5678);
    check("imm_strobe_c3", 64'(update_strobe), 64'h2);
    check("imm_freq0", 64'(fq(0)), 64'd0);
    check("imm_freq2", 64'(fq(2)), 64'd0);
    check("imm_freq3", 64'(fq(3)), 64'd0);
    step();
    check("imm_strobe_c4", 64'(update_strobe), 64'h0);

    // Round-robin: all four request together, ch0 re-requests during ch1 grant
    reset_dut();
    for (int k = 0; k < N_CH; k++) set_req(k, val[k]);
    for (int g = 0; g < 5; g++) begin
      step();
      check($sformatf("rr_ready_g%0d", g), 64'(req_bus.req_ready), 64'(4'b0001 << ord[g]));
      if (g == 1) set_req(0, val[4]);
      step();
      step();
      check($sformatf("rr_strobe_g%0d", g), 64'(update_strobe), 64'(4'b0001 << ord[g]));
      check($sformatf("rr_freq_g%0d", g), 64'(fq(int'(ord[g]))), 64'(val[g]));
    end

    // Sync mode: overwrite of a pending word, then one coherent commit
    reset_dut();
    mode_sync = 1'b1;
    set_req(0, 32'h0000_000A);
    step();
    step();
    check("sync_pend_a", 64'(pending), 64'h1);
    set_req(2, 32'h0000_000B);
    step();
    check("sync_ready_ch2", 64'(req_bus.req_ready), 64'h4);
    step();
    check("sync_pend_ab", 64'(pending), 64'h5);
    set_req(0, 32'h0000_000C);
    step();
    check("sync_ready_ch0", 64'(req_bus.req_ready), 64'h1);
    step();
    check("sync_pend_cb", 64'(pending), 64'h5);
    check("sync_lost", 64'(lost_cnt), 64'(LOST_EXP));
    check("sync_nocommit", 64'(fq(0)), 64'd0);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync_strobe_s1", 64'(update_strobe), 64'h0);
    step();
    check("sync_freq0", 64'(fq(0)), 64'h0000_000C);
    check("sync_freq2", 64'(fq(2)), 64'h0000_000B);
    check("sync_strobe_s2", 64'(update_strobe), 64'h5);
    check("sync_pend_clr", 64'(pending), 64'h0);

    // Sync with nothing pending is discarded
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("disc_busy", 64'(busy), 64'd0);
    step();
    check("disc_strobe", 64'(update_strobe), 64'h0);
    set_req(1, 32'h1111_2222);
    step();
    check("disc_ready_ch1", 64'(req_bus.req_ready), 64'h2);
    step();
    step();
    step();
    check("disc_pend_kept", 64'(pending), 64'h2);
    check("disc_freq1", 64'(fq(1)), 64'd0);

    // Sync during a GRANT of ch3 is held and commits 3 cycles later
    set_req(3, 32'hDEAD_BEEF);
    step();
    check("gsync_ready_ch3", 64'(req_bus.req_ready), 64'h8);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("gsync_strobe_s1", 64'(update_strobe), 64'h0);
    step();
    check("gsync_strobe_s2", 64'(update_strobe), 64'h0);
    step();
    check("gsync_freq3", 64'(fq(3)), 64'hDEAD_BEEF);
    check("gsync_freq1", 64'(fq(1)), 64'h1111_2222);
    check("gsync_strobe_s3", 64'(update_strobe), 64'hA);
    check("gsync_pend", 64'(pending), 64'h0);

    // Disabled channel is skipped, then served once re-enabled
    mode_sync = 1'b0;
    ch_en = 4'b1011;
    set_req(2, 32'hCAFE_0002);
    step();
    check("dis_dds_dis", 64'(dds_dis), 64'h4);
    check("dis_ready_a", 64'(req_bus.req_ready), 64'h0);
    check("dis_busy", 64'(busy), 64'd0);
    step();
    check("dis_ready_b", 64'(req_bus.req_ready), 64'h0);
    ch_en = 4'b1111;
    step();
    check("en_ready", 64'(req_bus.req_ready), 64'h4);
    check("en_dds_dis", 64'(dds_dis), 64'h0);
    step();
    step();
    check("en_freq2", 64'(fq(2)), 64'hCAFE_0002);
    check("en_strobe", 64'(update_strobe), 64'h4);

    // Reset during COMMIT, then arbitration restarts from ch0
    set_req(1, 32'h0BAD_F00D);
    step();
    check("rc_ready_ch1", 64'(req_bus.req_ready), 64'h2);
    step();
    check("rc_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rc_freq_lo", 64'(dds_freq[63:0]), 64'd0);
    check("rc_freq_hi", 64'(dds_freq[127:64]), 64'd0);
    check("rc_strobe", 64'(update_strobe), 64'h0);
    check("rc_pending", 64'(pending), 64'h0);
    check("rc_busy0", 64'(busy), 64'd0);
    check("rc_lost", 64'(lost_cnt), 64'd0);
    reset = 1'b0;
    req_bus.req_valid = '0;
    set_req(1, 32'h0101_0101);
    set_req(3, 32'h0303_0303);
    step();
    check("rc_rr_from0", 64'(req_bus.req_ready), 64'h2);
    step();
    step();
    check("rc_freq1", 64'(fq(1)), 64'h0101_0101);
    check("rc_strobe2", 64'(update_strobe), 64'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
